// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - MENU/COUNTDOWN/GAME/END_SCREEN game sequencer timed in video frames.
// Optional in-game pause is built when GAME_FLOW_PAUSE_EN is defined.
module game_flow_ctrl #(
    parameter int START_DELAY_FRAMES = 180,
    parameter int END_HOLD_FRAMES    = 120,
    parameter int FRAMES_W           = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                buttondown,
    input  logic                vblnk,
    input  logic [3:0]          current_health,
    input  logic [6:0]          boss_hp,
    output logic [1:0]          game_state,
    output logic                game_active,
    output logic                show_menu_end,
    output logic                round_rst,
    output logic                player_won,
    output logic [FRAMES_W-1:0] frames_left,
    output logic                paused
);
    typedef enum logic [1:0] {
        S_MENU      = 2'd0,
        S_GAME      = 2'd1,
        S_END       = 2'd2,
        S_COUNTDOWN = 2'd3
    } state_t;

    localparam logic [FRAMES_W-1:0] START_LOAD = FRAMES_W'(START_DELAY_FRAMES);
    localparam logic [FRAMES_W-1:0] END_LOAD   = FRAMES_W'(END_HOLD_FRAMES);
    localparam logic [FRAMES_W-1:0] CNT_ONE    = FRAMES_W'(1);
    localparam logic [FRAMES_W-1:0] CNT_ZERO   = '0;

    logic                r_sync1;
    logic                r_sync2;
    logic                r_btn_prev;
    logic                r_btn_rise;
    logic                r_vblnk_d;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [FRAMES_W-1:0] r_cnt;
    logic [FRAMES_W-1:0] w_cnt_nxt;
    logic [FRAMES_W-1:0] w_cnt_dec;
    logic [FRAMES_W-1:0] r_frames_left;
    logic                r_won;
    logic                w_won_nxt;
    logic                r_round_rst;
    logic                w_round_rst_nxt;
    logic                r_game_active;
    logic                w_active_nxt;
    logic                r_show_menu_end;
    logic                w_frame_tick;
    logic                w_round_over;
`ifdef GAME_FLOW_PAUSE_EN
    logic                r_paused;
    logic                w_paused_nxt;
`endif

    assign w_frame_tick = vblnk & ~r_vblnk_d;
    assign w_round_over = (current_health == 4'd0) || (boss_hp == 7'd0);
    // Saturating frame decrement; END_SCREEN judges the button on the pre-tick count.
    assign w_cnt_dec    = (w_frame_tick && (r_cnt != CNT_ZERO)) ? (r_cnt - CNT_ONE) : r_cnt;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_won_nxt       = r_won;
        w_round_rst_nxt = 1'b0;
`ifdef GAME_FLOW_PAUSE_EN
        w_paused_nxt    = r_paused;
`endif
        case (r_state)
            S_MENU: begin
                if (r_btn_rise) begin
                    w_state_nxt     = S_COUNTDOWN;
                    w_cnt_nxt       = START_LOAD;
                    w_round_rst_nxt = 1'b1;
                    w_won_nxt       = 1'b0;
                end
            end
            S_COUNTDOWN: begin
                if (w_frame_tick) begin
                    if (r_cnt <= CNT_ONE) begin
                        w_state_nxt = S_GAME;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt   = w_cnt_dec;
                    end
                end
            end
            S_GAME: begin
`ifdef GAME_FLOW_PAUSE_EN
                if (r_paused) begin
                    if (r_btn_rise) begin
                        w_paused_nxt = 1'b0;
                    end
                end else if (w_round_over) begin
                    w_state_nxt  = S_END;
                    w_cnt_nxt    = END_LOAD;
                    w_won_nxt    = (boss_hp == 7'd0) && (current_health != 4'd0);
                    w_paused_nxt = 1'b0;
                end else if (r_btn_rise) begin
                    w_paused_nxt = 1'b1;
                end
`else
                if (w_round_over) begin
                    w_state_nxt = S_END;
                    w_cnt_nxt   = END_LOAD;
                    w_won_nxt   = (boss_hp == 7'd0) && (current_health != 4'd0);
                end
`endif
            end
            S_END: begin
                w_cnt_nxt = w_cnt_dec;
                if (r_btn_rise && (r_cnt == CNT_ZERO)) begin
                    w_state_nxt = S_MENU;
                end
            end
            default: begin
                w_state_nxt = S_MENU;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
`ifdef GAME_FLOW_PAUSE_EN
        w_active_nxt = (w_state_nxt == S_GAME) && !w_paused_nxt;
`else
        w_active_nxt = (w_state_nxt == S_GAME);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1         <= 1'b0;
            r_sync2         <= 1'b0;
            r_btn_prev      <= 1'b0;
            r_btn_rise      <= 1'b0;
            r_vblnk_d       <= 1'b0;
            r_state         <= S_MENU;
            r_cnt           <= CNT_ZERO;
            r_won           <= 1'b0;
            r_round_rst     <= 1'b0;
            r_game_active   <= 1'b0;
            r_show_menu_end <= 1'b1;
            r_frames_left   <= CNT_ZERO;
`ifdef GAME_FLOW_PAUSE_EN
            r_paused        <= 1'b0;
`endif
        end else begin
            r_sync1         <= buttondown;
            r_sync2         <= r_sync1;
            r_btn_prev      <= r_sync2;
            // Edge flag is registered so the FSM acts three cycles after the pin.
            r_btn_rise      <= r_sync2 & ~r_btn_prev;
            r_vblnk_d       <= vblnk;
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_won           <= w_won_nxt;
            r_round_rst     <= w_round_rst_nxt;
            r_game_active   <= w_active_nxt;
            r_show_menu_end <= (w_state_nxt == S_MENU) || (w_state_nxt == S_END);
            r_frames_left   <= ((w_state_nxt == S_COUNTDOWN) || (w_state_nxt == S_END)) ?
                               w_cnt_nxt : CNT_ZERO;
`ifdef GAME_FLOW_PAUSE_EN
            r_paused        <= w_paused_nxt;
`endif
        end
    end

    assign game_state    = r_state;
    assign game_active   = r_game_active;
    assign show_menu_end = r_show_menu_end;
    assign round_rst     = r_round_rst;
    assign player_won    = r_won;
    assign frames_left   = r_frames_left;
`ifdef GAME_FLOW_PAUSE_EN
    assign paused        = r_paused;
`else
    assign paused        = 1'b0;
`endif
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer. Owns the MENU / COUNTDOWN / GAME / END_SCREEN flow that gates the background, platform, boss, character and weapon pipeline.
- Synchronises and edge-detects the menu button and times state holds in video frames (rising edges of vblnk).
- Issues a one-cycle round reset so the character and boss datapaths restart cleanly each round.
- Sits beside vga_timing in top_vga, clocked by the 65 MHz pixel clock; its outputs drive game_active/show_menu_end consumers.

Parameters:
- START_DELAY_FRAMES, 180: frames spent in COUNTDOWN before GAME (valid range 1..255).
- END_HOLD_FRAMES, 120: frames after entering END_SCREEN during which the button is ignored (valid range 1..255).
- FRAMES_W, 8: width of the frame counter and of frames_left.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- buttondown  in  1  raw asynchronous button level.
- vblnk  in  1  vertical blanking from vga_timing.
- current_health  in  4  player health; 0 = dead.
- boss_hp  in  7  boss health; 0 = defeated.
- game_state  out  2  0 = MENU, 1 = GAME, 2 = END_SCREEN, 3 = COUNTDOWN.
- game_active  out  1  high only in GAME (and not paused).
- show_menu_end  out  1  high in MENU or END_SCREEN.
- round_rst  out  1  one-cycle pulse at round start.
- player_won  out  1  result of the last round, valid in END_SCREEN.
- frames_left  out  FRAMES_W  remaining frames of COUNTDOWN or END hold, 0 otherwise.
- paused  out  1  pause indicator; tied 0 when PAUSE_EN is absent.

Behaviour:
- All outputs are registered. Reset values:
  - game_state = MENU, game_active = 0, show_menu_end = 1
  - round_rst = 0, player_won = 0, frames_left = 0, paused = 0
  - synchroniser flops = 0, vblnk history = 0
- Button path: 2-flop synchroniser, then a previous-value register. btn_rise = sync & ~prev. A level held high produces exactly one btn_rise. Pin to btn_rise latency is 3 cycles.
- frame_tick = vblnk & ~vblnk_d: one cycle per frame.
- MENU:
  - On btn_rise: go to COUNTDOWN, pulse round_rst for one cycle (the cycle game_state becomes 3), load counter = START_DELAY_FRAMES.
- COUNTDOWN:
  - Each frame_tick decrements the counter.
  - A frame_tick with counter == 1 moves to GAME and sets counter = 0.
  - Button is ignored.
  - Health inputs are ignored, because the datapaths are still reloading.
- GAME:
  - If current_health == 0 or boss_hp == 0: go to END_SCREEN, load counter = END_HOLD_FRAMES, latch player_won = (boss_hp == 0) && (current_health != 0).
  - If both are zero in the same cycle, the player loses (player_won = 0).
- END_SCREEN:
  - frame_tick decrements the counter while it is nonzero. Inputs are otherwise ignored.
  - btn_rise while counter != 0 is discarded; it is not queued.
  - btn_rise while counter == 0 moves to MENU. player_won holds until the next round_rst clears it.
- Output decode (registered):
  - game_state: state encoding as listed under Ports.
  - frames_left: counter value in COUNTDOWN and END_SCREEN, 0 elsewhere.
  - game_active / show_menu_end: decoded from the state as defined under Ports.
- Simultaneous events:
  - btn_rise and frame_tick in the same cycle: the frame_tick is applied first, and the button is judged against the pre-tick counter.
  - rst has priority over everything, including mid-countdown and during a round_rst pulse.
- Counter arithmetic: unsigned FRAMES_W bits, never decremented below 0, no wrap.

Optional Feature:
- Macro: GAME_FLOW_PAUSE_EN.
- When defined:
  - btn_rise in GAME toggles the internal paused flag.
  - While paused, game_active = 0, paused = 1, game_state stays 1, and health checks are suspended.
  - The next btn_rise resumes play, and game_active returns the following cycle.
  - The flag is cleared on rst and on every exit from GAME.
- When undefined:
  - btn_rise in GAME is ignored and paused is constant 0.

Test Plan:
- Reset, then hold buttondown high for 10 cycles starting at cycle 5 -> round_rst high exactly one cycle at cycle 9; game_state = 3; frames_left = 180.
- Run 180 frame_ticks in COUNTDOWN -> game_state = 1 and game_active = 1 on the cycle after the 180th tick; frames_left = 0.
- In GAME, drive boss_hp = 0 with current_health = 5 -> game_state = 2, player_won = 1, frames_left = 120; next repeat with both = 0 in the same cycle -> player_won = 0.
- In END_SCREEN, pulse the button after 50 frames -> stays in 2. After 120 frames, pulse again -> game_state = 0, show_menu_end = 1, round_rst = 0.
- Assert rst mid-COUNTDOWN (frames_left = 90) -> next cycle game_state = 0, frames_left = 0, all outputs at reset values.
- With GAME_FLOW_PAUSE_EN defined: pulse the button in GAME, then drive current_health = 0 -> paused = 1, game_active = 0, state stays 1. Pulse again -> END_SCREEN entered within 2 cycles.
